// File: rtl/adler32_ctrl_pkg.sv
// Shared definitions for the adler32 sequencer: state encoding, checksum
// constants and core pacing.
package pkg_adler32;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_RDY   = 3'd2;
  localparam logic [2:0] ST_BUSY  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_HOLD  = 3'd5;

  localparam int          ADLER32_MOD  = 65521;
  localparam logic [31:0] ADLER32_INIT = 32'h0000_0001;
  localparam int          ADLER32_PACE = 4;

  // Accept cycle plus BUSY cycles counting PACE_LOAD..0 spans ADLER32_PACE cycles.
  localparam logic [1:0] PACE_LOAD = 2'(ADLER32_PACE - 2);

endpackage

// File: rtl/adler32_ctrl_if.sv
// Upstream word stream from the zlib assembler into the adler32 sequencer.
interface adler32_ctrl_if #(
  parameter int DATA_WD = 32
);
  logic               s_val_i;
  logic [DATA_WD-1:0] s_dat_i;
  logic               s_lst_i;
  logic               s_rdy_o;

  modport master (output s_val_i, output s_dat_i, output s_lst_i, input s_rdy_o);
  modport slave  (input s_val_i, input s_dat_i, input s_lst_i, output s_rdy_o);
endinterface

// File: rtl/adler32_ctrl.sv
// Sequencer between the zlib stream assembler and one adler32 core.
// Optional word counter output wcnt_o enabled by ADLER32_CTRL_WCNT_EN.
module adler32_ctrl
  import pkg_adler32::*;
#(
  parameter int DATA_WD = 32,
  parameter int CNT_WD  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  adler32_ctrl_if.slave      s,
  output logic               adl_start_o,
  output logic               adl_val_o,
  output logic [DATA_WD-1:0] adl_dat_o,
  output logic               adl_lst_o,
  input  logic               adl_done_i,
  input  logic [31:0]        adl_dat_i,
  output logic               chk_val_o,
  output logic [31:0]        chk_dat_o,
  input  logic               chk_rdy_i,
  output logic               busy_o
`ifdef ADLER32_CTRL_WCNT_EN
  ,
  output logic [CNT_WD-1:0]  wcnt_o
`endif
);

  logic [2:0] state;
  logic [1:0] pace_cnt;
  logic       in_rdy;
  logic       xfer;

  assign in_rdy = (state == ST_RDY);
  assign xfer   = in_rdy & s.s_val_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pace_cnt  <= '0;
      chk_dat_o <= '0;
    end else begin
      case (state)
        ST_IDLE: if (start_i) state <= ST_ARM;
        // Core needs one cycle after start before it accepts a word.
        ST_ARM:  state <= ST_RDY;
        ST_RDY: begin
          if (s.s_val_i) begin
            if (s.s_lst_i) begin
              state <= ST_DRAIN;
            end else begin
              state    <= ST_BUSY;
              pace_cnt <= PACE_LOAD;
            end
          end
        end
        ST_BUSY: begin
          if (pace_cnt == 2'd0) state <= ST_RDY;
          else                  pace_cnt <= pace_cnt - 2'd1;
        end
        ST_DRAIN: begin
          if (adl_done_i) begin
            chk_dat_o <= adl_dat_i;
            state     <= ST_HOLD;
          end
        end
        ST_HOLD: if (chk_rdy_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Word path is combinational so the core sees byte [31:24] in the accept cycle.
  always_comb begin
    adl_start_o = (state == ST_IDLE) & start_i;
    s.s_rdy_o   = in_rdy;
    adl_val_o   = xfer;
    adl_dat_o   = in_rdy ? s.s_dat_i : '0;
    adl_lst_o   = in_rdy & s.s_lst_i;
    chk_val_o   = (state == ST_HOLD);
    busy_o      = (state != ST_IDLE);
  end

`ifdef ADLER32_CTRL_WCNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      wcnt_o <= '0;
    end else if ((state == ST_IDLE) && start_i) begin
      wcnt_o <= '0;
    end else if (xfer && (wcnt_o != {CNT_WD{1'b1}})) begin
      wcnt_o <= wcnt_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_adler32_ctrl.sv
// Directed bench for adler32_ctrl with a behavioural adler32 core model.
module tb_adler32_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        adl_start, adl_val, adl_lst, adl_done, core_done, inj_done;
  logic [31:0] adl_dat_o, adl_dat_i;
  logic        chk_val, chk_rdy, busy;
  logic [31:0] chk_dat;
`ifdef ADLER32_CTRL_WCNT_EN
  logic [15:0] wcnt;
`endif

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;

  adler32_ctrl_if #(.DATA_WD(32)) s_if ();

  adler32_ctrl #(.DATA_WD(32), .CNT_WD(16)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .s(s_if.slave),
    .adl_start_o(adl_start), .adl_val_o(adl_val), .adl_dat_o(adl_dat_o),
    .adl_lst_o(adl_lst), .adl_done_i(adl_done), .adl_dat_i(adl_dat_i),
    .chk_val_o(chk_val), .chk_dat_o(chk_dat), .chk_rdy_i(chk_rdy), .busy_o(busy)
`ifdef ADLER32_CTRL_WCNT_EN
    , .wcnt_o(wcnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural core: word accepted at t, done_o high in cycle t+4 for the last word.
  int   m_s1, m_s2, m_pend;
  logic m_actv, m_last;
  assign adl_done = core_done | inj_done;
  assign adl_dat_i = {m_s2[15:0], m_s1[15:0]};

  always @(posedge clk) begin
    if (rst) begin
      m_actv = 1'b0; m_pend = 0; m_last = 1'b0; core_done <= 1'b0;
      m_s1 = 1; m_s2 = 0;
    end else begin
      core_done <= 1'b0;
      if (m_pend != 0) begin
        if (m_pend == 1 && m_last) begin core_done <= 1'b1; m_actv = 1'b0; end
        m_pend = m_pend - 1;
      end
      if (adl_start) begin m_actv = 1'b1; m_s1 = 1; m_s2 = 0; end
      else if (m_actv && adl_val && m_pend == 0) begin
        for (int b = 3; b >= 0; b--) begin
          m_s1 = (m_s1 + int'(adl_dat_o[b*8 +: 8])) % 65521;
          m_s2 = (m_s2 + m_s1) % 65521;
        end
        m_pend = 3;
        m_last = adl_lst;
      end
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Runs one stream; leaves the DUT in HOLD (unless chk_rdy is already high).
  task automatic send_stream(input logic [31:0] w [4], input int n, input bit poke_busy,
                             output int acc_cyc [4], output int chk_cyc,
                             output logic [31:0] got);
    int guard;
    bit acc;
    chk_cyc = -1; got = '0;
    start_i = 1'b1; #1;
    if (adl_start !== 1'b1) $display("FAIL start_pass adl_start_o=%b want 1", adl_start);
    else n_pass++;
    n_chk++;
    tick; start_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      s_if.s_val_i = 1'b1; s_if.s_dat_i = w[i]; s_if.s_lst_i = (i == n - 1);
      acc = 0; guard = 0; acc_cyc[i] = -1;
      while (!acc && guard < 40) begin
        #1;
        if (s_if.s_rdy_o === 1'b1) begin
          acc = 1; acc_cyc[i] = cyc;
          if ({adl_val, adl_dat_o} !== {1'b1, w[i]})
            $display("FAIL passthru val/dat=%b/%h want 1/%h", adl_val, adl_dat_o, w[i]);
          else n_pass++;
          n_chk++;
        end
        tick; guard++;
      end
      if (!acc) begin $display("FAIL accept_timeout word=%0d", i); n_chk++; end
      if (poke_busy && i == 0) begin
        start_i = 1'b1; #1;
        if ({adl_start, busy, s_if.s_rdy_o} !== 3'b010)
          $display("FAIL start_in_busy start/busy/rdy=%b want 010", {adl_start, busy, s_if.s_rdy_o});
        else n_pass++;
        n_chk++;
        start_i = 1'b0;
      end
    end
    s_if.s_val_i = 1'b0; s_if.s_lst_i = 1'b0; s_if.s_dat_i = '0;
    guard = 0;
    while (chk_val !== 1'b1 && guard < 40) begin tick; guard++; end
    if (chk_val === 1'b1) begin chk_cyc = cyc; got = chk_dat; end
    else begin $display("FAIL chk_timeout chk_val=%b", chk_val); n_chk++; end
  endtask

  task automatic release_hold;
    chk_rdy = 1'b1; tick; chk_rdy = 1'b0;
    if ({busy, chk_val} !== 2'b00) $display("FAIL release busy/chk_val=%b want 00", {busy, chk_val});
    else n_pass++;
    n_chk++;
  endtask

  task automatic check_single(input logic [31:0] word, input logic [31:0] exp, input string nm);
    logic [31:0] w [4];
    int a [4];
    int c;
    logic [31:0] got;
    w = '{word, 0, 0, 0};
    send_stream(w, 1, 1'b0, a, c, got);
    if (got !== exp) $display("FAIL %s chk_dat=%h want %h", nm, got, exp);
    else n_pass++;
    n_chk++;
    if (c - a[0] !== 5) $display("FAIL %s_latency got %0d want 5", nm, c - a[0]);
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_reset;
    rst = 1'b1; start_i = 1'b0; chk_rdy = 1'b0; inj_done = 1'b0;
    s_if.s_val_i = 1'b0; s_if.s_dat_i = '0; s_if.s_lst_i = 1'b0;
    repeat (3) tick;
    rst = 1'b0; #1;
    if ({s_if.s_rdy_o, busy, chk_val, adl_start, adl_val, adl_lst} !== 6'b0)
      $display("FAIL reset_ctrl rdy/busy/cv/st/val/lst=%b want 000000",
               {s_if.s_rdy_o, busy, chk_val, adl_start, adl_val, adl_lst});
    else n_pass++;
    n_chk++;
    if ({chk_dat, adl_dat_o} !== 64'h0) $display("FAIL reset_data chk=%h adl=%h want 0", chk_dat, adl_dat_o);
    else n_pass++;
    n_chk++;
    tick;
  endtask

  task automatic test_single_abcd;
    int k;
    check_single(32'h6162_6364, 32'h03D8_018B, "single_abcd");
    for (k = 0; k < 10; k++) begin
      if ({chk_val, chk_dat} !== {1'b1, 32'h03D8_018B}) break;
      tick;
    end
    if (k !== 10) $display("FAIL hold_stable cycle=%0d val/dat=%b/%h", k, chk_val, chk_dat);
    else n_pass++;
    n_chk++;
    start_i = 1'b1; #1;
    if (adl_start !== 1'b0) $display("FAIL start_in_hold adl_start_o=%b want 0", adl_start);
    else n_pass++;
    n_chk++;
    tick; start_i = 1'b0;
    if ({busy, chk_val} !== 2'b11) $display("FAIL hold_after_start busy/cv=%b want 11", {busy, chk_val});
    else n_pass++;
    n_chk++;
    chk_rdy = 1'b1; start_i = 1'b1; tick; chk_rdy = 1'b0; start_i = 1'b0;
    if ({busy, chk_val} !== 2'b00) $display("FAIL start_with_handshake busy/cv=%b want 00", {busy, chk_val});
    else n_pass++;
    n_chk++;
    tick;
    if (busy !== 1'b0) $display("FAIL start_with_handshake_idle busy=%b want 0", busy);
    else n_pass++;
    n_chk++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] w [4];
    int a [4];
    int c;
    logic [31:0] got;
    w = '{32'h6162_6364, 32'h6566_6768, 0, 0};
    send_stream(w, 2, 1'b1, a, c, got);
    if (a[1] - a[0] !== 4) $display("FAIL accept_gap got %0d want 4", a[1] - a[0]);
    else n_pass++;
    n_chk++;
    if (got !== 32'h0E00_0325) $display("FAIL two_words chk_dat=%h want 0e000325", got);
    else n_pass++;
    n_chk++;
    release_hold;
  endtask

  task automatic test_boundary_words;
    check_single(32'h0000_0000, 32'h0004_0001, "zero_word");
    release_hold;
    check_single(32'hFFFF_FFFF, 32'h09FA_03FD, "ones_word");
    release_hold;
  endtask

  task automatic test_reset_mid;
    int guard = 0;
    start_i = 1'b1; tick; start_i = 1'b0;
    s_if.s_val_i = 1'b1; s_if.s_dat_i = 32'h1234_5678; s_if.s_lst_i = 1'b0;
    while (s_if.s_rdy_o !== 1'b1 && guard < 10) begin tick; guard++; end
    tick;
    s_if.s_val_i = 1'b0;
    if (busy !== 1'b1 || s_if.s_rdy_o !== 1'b0) $display("FAIL mid_busy busy/rdy=%b want 10", {busy, s_if.s_rdy_o});
    else n_pass++;
    n_chk++;
    rst = 1'b1; tick;
    if ({busy, s_if.s_rdy_o, chk_val, adl_val, adl_start} !== 5'b0 || {chk_dat, adl_dat_o} !== 64'h0)
      $display("FAIL reset_mid ctrl=%b chk=%h adl=%h want 0",
               {busy, s_if.s_rdy_o, chk_val, adl_val, adl_start}, chk_dat, adl_dat_o);
    else n_pass++;
    n_chk++;
    rst = 1'b0; tick;
    check_single(32'h0000_0000, 32'h0004_0001, "after_reset");
    release_hold;
  endtask

  task automatic test_early_rdy;
    logic [31:0] w [4];
    int a [4];
    int c;
    logic [31:0] got;
    w = '{32'h6162_6364, 0, 0, 0};
    chk_rdy = 1'b1;
    send_stream(w, 1, 1'b0, a, c, got);
    if (got !== 32'h03D8_018B) $display("FAIL early_rdy chk_dat=%h want 03d8018b", got);
    else n_pass++;
    n_chk++;
    tick;
    if ({chk_val, busy} !== 2'b00) $display("FAIL early_rdy_clear cv/busy=%b want 00", {chk_val, busy});
    else n_pass++;
    n_chk++;
    chk_rdy = 1'b0;
  endtask

  task automatic test_done_ignored;
    inj_done = 1'b1; tick; inj_done = 1'b0; tick;
    if ({busy, chk_val} !== 2'b00) $display("FAIL done_in_idle busy/cv=%b want 00", {busy, chk_val});
    else n_pass++;
    n_chk++;
  endtask

`ifdef ADLER32_CTRL_WCNT_EN
  task automatic test_wcnt;
    logic [31:0] w [4];
    int a [4];
    int c;
    logic [31:0] got;
    w = '{0, 0, 0, 0};
    send_stream(w, 3, 1'b0, a, c, got);
    if (got !== 32'h000C_0001) $display("FAIL wcnt_stream chk_dat=%h want 000c0001", got);
    else n_pass++;
    n_chk++;
    if (wcnt !== 16'd3) $display("FAIL wcnt_hold wcnt=%0d want 3", wcnt);
    else n_pass++;
    n_chk++;
    release_hold;
    if (wcnt !== 16'd3) $display("FAIL wcnt_idle wcnt=%0d want 3", wcnt);
    else n_pass++;
    n_chk++;
    start_i = 1'b1; tick; start_i = 1'b0;
    if (wcnt !== 16'd0) $display("FAIL wcnt_clear wcnt=%0d want 0", wcnt);
    else n_pass++;
    n_chk++;
    rst = 1'b1; tick; rst = 1'b0; tick;
  endtask
`endif

  initial begin
    test_reset;
    test_single_abcd;
    test_back_to_back;
    test_boundary_words;
    test_reset_mid;
    test_early_rdy;
    test_done_ignored;
`ifdef ADLER32_CTRL_WCNT_EN
    test_wcnt;
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
